// File: rtl/logic_pipe_pkg.sv
// -----------------------------------------------------------------------------
// logic_pipe_pkg
// Shared types and helpers for the logic_pipe_chain timing-test block.
//   logic_mode_e : per-item operation select carried down the pipe
//   apply_mode   : the logic cone between register rank 0 and rank 1
//   STATS_W      : width of the optional transfer/stall counters
// Optional feature macro used by the top: LOGIC_PIPE_STATS_EN.
// -----------------------------------------------------------------------------
package logic_pipe_pkg;

    typedef enum logic [1:0] {
        PASS       = 2'd0,
        AND_B      = 2'd1,
        OR_G_XOR_F = 2'd2,
        XNOR_B     = 2'd3
    } logic_mode_e;

    localparam int STATS_W = 16;

    // apply_mode works on a fixed maximum width so it can live in the package;
    // callers zero-extend their operands and truncate the result back to
    // their own width. All operations are bitwise, so the upper bits never
    // affect the lower ones. Datapaths wider than MODE_MAX_W are not supported.
    localparam int MODE_MAX_W = 64;

    function automatic logic [MODE_MAX_W-1:0] apply_mode(
        input logic_mode_e           mode,
        input logic [MODE_MAX_W-1:0] d,
        input logic [MODE_MAX_W-1:0] b,
        input logic [MODE_MAX_W-1:0] g,
        input logic [MODE_MAX_W-1:0] f
    );
        case (mode)
            PASS:       apply_mode = d;
            AND_B:      apply_mode = d & b;
            OR_G_XOR_F: apply_mode = (d | g) ^ f;
            XNOR_B:     apply_mode = ~(d ^ b);
            default:    apply_mode = d;
        endcase
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// -----------------------------------------------------------------------------
// logic_pipe_stage
// One register rank of logic_pipe_chain: a valid flag plus a payload register.
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : clears the valid flag on the next edge; payload holds
//   load       : the upstream rank hands an item to this rank this cycle
//   advance    : this rank's item leaves downstream this cycle
//   d          : payload presented by the upstream rank
//   valid, q   : registered valid flag and payload
// -----------------------------------------------------------------------------
module logic_pipe_stage
    import logic_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          advance,
    input  logic [PW-1:0] d,
    output logic          valid,
    output logic [PW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            // load wins over advance: an item leaving while a new one
            // arrives keeps the rank occupied.
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (advance) begin
                valid <= 1'b0;
            end
            // A flushed item is dropped, so the payload is left untouched.
            if (load && !flush) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/logic_pipe_chain.sv
// -----------------------------------------------------------------------------
// logic_pipe_chain
// STAGES-deep registered datapath with a valid/ready handshake. Rank 0
// captures {mode, d, b, g, f}, rank 1 registers apply_mode() of rank 0, and
// the remaining ranks are pure delay. Bubbles collapse, so the chain accepts
// one item per cycle when the output is draining.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : clears every valid on the next edge (data holds)
//   in_valid / in_ready : input handshake; in_ready is combinational from
//                         out_ready through the whole chain
//   in_mode, in_d, in_b, in_g, in_f : item operands (WIDTH <= 64)
//   out_valid / out_ready : output handshake
//   out_q               : registered result of the last rank
//   occupancy           : number of ranks currently holding an item
//   xfer_cnt, stall_cnt : saturating counters, present only when the macro
//                         LOGIC_PIPE_STATS_EN is defined
// -----------------------------------------------------------------------------
module logic_pipe_chain
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [WIDTH-1:0]              in_d,
    input  logic [WIDTH-1:0]              in_b,
    input  logic [WIDTH-1:0]              in_g,
    input  logic [WIDTH-1:0]              in_f,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_q,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
`ifdef LOGIC_PIPE_STATS_EN
    ,
    output logic [STATS_W-1:0]            xfer_cnt,
    output logic [STATS_W-1:0]            stall_cnt
`endif
);

    localparam int OCC_W = $clog2(STAGES+1);
    localparam int P0_W  = 2 + 4*WIDTH;

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] adv;
    logic              in_xfer;

    logic [P0_W-1:0]   pay_in;
    logic [P0_W-1:0]   pay_p0;
    logic [1:0]        mode_p0;
    logic [WIDTH-1:0]  d_p0;
    logic [WIDTH-1:0]  b_p0;
    logic [WIDTH-1:0]  g_p0;
    logic [WIDTH-1:0]  f_p0;
    logic [WIDTH-1:0]  res_comb;
    logic [WIDTH-1:0]  res_p [1:STAGES-1];

    // Advance chain, resolved from the output end backwards so a stall at
    // the output propagates to in_ready within the same cycle.
    always_comb begin
        logic [STAGES-1:0] a;
        a = '0;
        a[STAGES-1] = vld_p[STAGES-1] & out_ready;
        for (int k = STAGES-2; k >= 0; k--) begin
            a[k] = vld_p[k] & (~vld_p[k+1] | a[k+1]);
        end
        adv = a;
    end

    assign in_ready = ~vld_p[0] | adv[0];
    // A flush still lets in_xfer happen at the ports; the stage drops it.
    assign in_xfer  = in_valid & in_ready;

    // ---- stage 0: capture item operands and mode ----
    assign pay_in = {in_mode, in_d, in_b, in_g, in_f};

    logic_pipe_stage #(.PW(P0_W)) u_stage0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (in_xfer),
        .advance (adv[0]),
        .d       (pay_in),
        .valid   (vld_p[0]),
        .q       (pay_p0)
    );

    assign {mode_p0, d_p0, b_p0, g_p0, f_p0} = pay_p0;

    // ---- stage 1: register the mode-selected logic result ----
    assign res_comb = WIDTH'(apply_mode(logic_mode_e'(mode_p0),
                                        MODE_MAX_W'(d_p0),
                                        MODE_MAX_W'(b_p0),
                                        MODE_MAX_W'(g_p0),
                                        MODE_MAX_W'(f_p0)));

    // ---- stages 2..STAGES-1: pure delay of the stage-1 result ----
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (k == 1) begin : g_compute
            assign stage_d = res_comb;
        end else begin : g_delay
            assign stage_d = res_p[k-1];
        end

        logic_pipe_stage #(.PW(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .load    (adv[k-1]),
            .advance (adv[k]),
            .d       (stage_d),
            .valid   (vld_p[k]),
            .q       (res_p[k])
        );
    end

    assign out_valid = vld_p[STAGES-1];
    assign out_q     = res_p[STAGES-1];

    // Popcount of registered valids, so it only moves on clock edges.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(vld_p[k]);
        end
    end

`ifdef LOGIC_PIPE_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] c);
        return (&c) ? c : c + STATS_W'(1);
    endfunction

    // Counters survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                xfer_cnt <= sat_inc(xfer_cnt);
            end
            if (out_valid && !out_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
